// File: rtl/dpr_arb_pkg.sv
// dpr_arbiter shared constants and helpers.
// Sizes, port indices and the same-address hazard rule.
package dpr_arb_pkg;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int AW    = 12;
  localparam int PW    = 2;
  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  // Two accesses collide when they share an address and either writes.
  function automatic logic hazard(
    input logic [AW-1:0] a0,
    input logic [AW-1:0] a1,
    input logic          w0,
    input logic          w1
  );
    return (a0 == a1) && (w0 || w1);
  endfunction

endpackage

// File: rtl/dpr_arbiter_if.sv
// Requester-side bus of the dual-port RAM arbiter.
// master = requesters, slave = arbiter.
interface dpr_arbiter_if;
  import dpr_arb_pkg::*;

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [NREQ*DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dpr_arbiter_rr_pick2.sv
// Two-winner round-robin picker for dpr_arbiter.
// Second winner skips requesters that collide with the first.
module rr_pick2
  import dpr_arb_pkg::*;
(
  input  logic [PW-1:0]      ptr,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]    gnt,
  output logic               a_v,
  output logic [PW-1:0]      a_i,
  output logic               b_v,
  output logic [PW-1:0]      b_i,
  output logic [PW-1:0]      last,
  output logic               skip
);

  logic [PW-1:0] idx;

  // Scan from ptr; first hit is A, next non-colliding hit is B.
  always_comb begin
    a_v  = 1'b0;
    a_i  = '0;
    b_v  = 1'b0;
    b_i  = '0;
    skip = 1'b0;
    idx  = '0;
    gnt  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + PW'(k);
      if (req[idx]) begin
        if (!a_v) begin
          a_v = 1'b1;
          a_i = idx;
        end else if (!b_v) begin
          if (hazard(addr[a_i*AW +: AW],
                     addr[idx*AW +: AW],
                     we[a_i], we[idx])) begin
            skip = 1'b1;
          end else begin
            b_v = 1'b1;
            b_i = idx;
          end
        end
      end
    end
    if (a_v) gnt[a_i] = 1'b1;
    if (b_v) gnt[b_i] = 1'b1;
    last = b_v ? b_i : a_i;
  end

endmodule

// File: rtl/dpr_arbiter.sv
// Round-robin arbiter/sequencer for a true dual-port RAM.
// DPR_ARB_STATS_EN adds a saturating conflict_cnt output.
module dpr_arbiter
  import dpr_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  dpr_arbiter_if.slave  bus,
  output logic          ram_wr_en_0,
  output logic          ram_wr_en_1,
  output logic [AW-1:0] ram_addr_0,
  output logic [AW-1:0] ram_addr_1,
  output logic [DW-1:0] ram_in_0,
  output logic [DW-1:0] ram_in_1,
  input  logic [DW-1:0] ram_out_0,
  input  logic [DW-1:0] ram_out_1
`ifdef DPR_ARB_STATS_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);

  logic [PW-1:0]      ptr;
  logic [NREQ-1:0]    pgnt;
  logic               a_v;
  logic               b_v;
  logic [PW-1:0]      a_i;
  logic [PW-1:0]      b_i;
  logic [PW-1:0]      last;
  logic               skip;
  logic [1:0]         rt_v;
  logic [PW-1:0]      rt_i [2];
  logic [NREQ-1:0]    rv;
  logic [NREQ*DW-1:0] rd;

  rr_pick2 u_pick (
    .ptr  (ptr),
    .req  (bus.req),
    .we   (bus.we),
    .addr (bus.addr),
    .gnt  (pgnt),
    .a_v  (a_v),
    .a_i  (a_i),
    .b_v  (b_v),
    .b_i  (b_i),
    .last (last),
    .skip (skip)
  );

  assign bus.gnt = rst ? '0 : pgnt;

  // Winner A drives RAM port 0, winner B port 1; idle ports read zero.
  always_comb begin
    ram_wr_en_0 = 1'b0;
    ram_addr_0  = '0;
    ram_in_0    = '0;
    ram_wr_en_1 = 1'b0;
    ram_addr_1  = '0;
    ram_in_1    = '0;
    if (!rst && a_v) begin
      ram_wr_en_0 = bus.we[a_i];
      ram_addr_0  = bus.addr[a_i*AW +: AW];
      ram_in_0    = bus.wdata[a_i*DW +: DW];
    end
    if (!rst && b_v) begin
      ram_wr_en_1 = bus.we[b_i];
      ram_addr_1  = bus.addr[b_i*AW +: AW];
      ram_in_1    = bus.wdata[b_i*DW +: DW];
    end
  end

  // Advance pointer past last winner and remember who each read is for.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      rt_v        <= '0;
      rt_i[PORT0] <= '0;
      rt_i[PORT1] <= '0;
    end else begin
      if (a_v) ptr <= last + PW'(1);
      rt_v[PORT0] <= a_v && !bus.we[a_i];
      rt_v[PORT1] <= b_v && !bus.we[b_i];
      rt_i[PORT0] <= a_i;
      rt_i[PORT1] <= b_i;
    end
  end

  // Steer registered RAM data to the requester that issued the read.
  always_comb begin
    rv = '0;
    rd = '0;
    if (!rst && rt_v[PORT0]) begin
      rv[rt_i[PORT0]]          = 1'b1;
      rd[rt_i[PORT0]*DW +: DW] = ram_out_0;
    end
    if (!rst && rt_v[PORT1]) begin
      rv[rt_i[PORT1]]          = 1'b1;
      rd[rt_i[PORT1]*DW +: DW] = ram_out_1;
    end
  end

  assign bus.rvalid = rv;
  assign bus.rdata  = rd;

`ifdef DPR_ARB_STATS_EN
  // Count cycles where a colliding requester was deferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (skip && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`else
  logic unused_skip;
  assign unused_skip = skip;
`endif

endmodule
